// File: rtl/svfloat_sign_pipe_if.sv
// Stream interface for svfloat_sign_pipe.
// Carries the input beat (valid/ready, op, NaN sign policy, operands, tag)
// and the result beat (valid/ready, lane results, tag, per-lane NaN flags).
//   slave  : the sign unit's view (consumes in_*, produces out_*)
//   master : the producer/consumer view around the unit
interface svfloat_sign_pipe_if #(
    parameter int LANES = 1,
    parameter int FW    = 32,
    parameter int TAG_W = 1
);
    logic                        in_valid;
    logic                        in_ready;
    logic [2:0]                  in_op;
    logic                        in_presv_nan;
    logic [LANES-1:0][FW-1:0]    in_a;
    logic [LANES-1:0][FW-1:0]    in_b;
    logic [TAG_W-1:0]            in_tag;
    logic                        out_valid;
    logic                        out_ready;
    logic [LANES-1:0][FW-1:0]    out_res;
    logic [TAG_W-1:0]            out_tag;
    logic [LANES-1:0]            out_nan;

    modport slave (
        input  in_valid, in_op, in_presv_nan, in_a, in_b, in_tag, out_ready,
        output in_ready, out_valid, out_res, out_tag, out_nan
    );

    modport master (
        output in_valid, in_op, in_presv_nan, in_a, in_b, in_tag, out_ready,
        input  in_ready, out_valid, out_res, out_tag, out_nan
    );
endinterface

// File: rtl/svfloat_sign_pipe.sv
// Multi-lane pipelined floating-point sign manipulation unit.
// Ops: 0 PASS, 1 NEG, 2 ABS, 3 SGNJ, 4 SGNJN, 5 SGNJX, 6 NABS, 7 PASS.
// Exponent/mantissa always come from a; only the sign is rewritten.
// Ports:
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset
//   io   : svfloat_sign_pipe_if.slave (in_* beat in, out_* beat out)
// Latency STAGES cycles, 1 beat/cycle throughput, bubbles collapse.
package svfloat;
    typedef struct packed {
        logic        sign;
        logic [7:0]  exponent;
        logic [22:0] mantissa;
    } float32;
endpackage

// Per-lane combinational sign logic.
module svfloat_sign_lane #(
    parameter type float     = svfloat::float32,
    parameter bit  CANON_NAN = 1'b0
) (
    input  logic [2:0] op,
    input  logic       presv_nan,
    input  float       a,
    input  logic       b_sign,
    output float       res,
    output logic       nan
);
    logic s;

    always_comb begin
        nan = (&a.exponent) && (|a.mantissa);
        case (op)
            3'd1:    s = ~a.sign;
            3'd2:    s = 1'b0;
            3'd3:    s = b_sign;
            3'd4:    s = ~b_sign;
            3'd5:    s = a.sign ^ b_sign;
            3'd6:    s = 1'b1;
            default: s = a.sign;
        endcase
        res      = a;
        res.sign = (nan && presv_nan) ? a.sign : s;
        if (CANON_NAN && nan) begin
            // canonical quiet NaN: +, exp all ones, only mantissa MSB set
            res          = '0;
            res.exponent = '1;
            res.mantissa = {1'b1, {($bits(a.mantissa)-1){1'b0}}};
        end
    end
endmodule

module svfloat_sign_pipe #(
    parameter type float     = svfloat::float32,
    parameter int  LANES     = 1,
    parameter int  STAGES    = 1,
    parameter int  TAG_W     = 1,
    parameter bit  CANON_NAN = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    svfloat_sign_pipe_if.slave io
);
    localparam int FW = $bits(float);

    typedef struct packed {
        logic [LANES-1:0][FW-1:0] res;
        logic [TAG_W-1:0]         tag;
        logic [LANES-1:0]         nan;
    } beat_t;

    logic [LANES-1:0][FW-1:0] lane_res;
    logic [LANES-1:0]         lane_nan;
    beat_t                    in_beat;
    beat_t                    stg_data [STAGES];
    logic [STAGES-1:0]        vld_pipe;
    logic [STAGES-1:0]        load;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        // b contributes only its sign, which is the MSB of the packed float
        svfloat_sign_lane #(.float(float), .CANON_NAN(CANON_NAN)) u_lane (
            .op        (io.in_op),
            .presv_nan (io.in_presv_nan),
            .a         (io.in_a[i]),
            .b_sign    (io.in_b[i][FW-1]),
            .res       (lane_res[i]),
            .nan       (lane_nan[i])
        );
    end

    assign in_beat = {lane_res, io.in_tag, lane_nan};

    // Stage k may load when empty or when its successor loads; walking from
    // the output back lets empty slots absorb beats behind a stalled output.
    always_comb begin
        logic go;
        go   = io.out_ready;
        load = '0;
        for (int k = STAGES - 1; k >= 0; k--) begin
            go      = !vld_pipe[k] || go;
            load[k] = go;
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stg
        logic  vld_q;
        beat_t data_q;
        logic  src_vld;
        beat_t src;

        if (k == 0) begin : g_head
            assign src_vld = io.in_valid;
            assign src     = in_beat;
        end else begin : g_body
            assign src_vld = vld_pipe[k-1];
            assign src     = stg_data[k-1];
        end

        // payload only moves when a real beat arrives
        always_ff @(posedge clk) begin
            if (rst) begin
                vld_q  <= 1'b0;
                data_q <= '0;
            end else if (load[k]) begin
                vld_q <= src_vld;
                if (src_vld) data_q <= src;
            end
        end

        assign vld_pipe[k] = vld_q;
        assign stg_data[k] = data_q;
    end

    assign io.in_ready  = load[0];
    assign io.out_valid = vld_pipe[STAGES-1];
    assign io.out_res   = stg_data[STAGES-1].res;
    assign io.out_tag   = stg_data[STAGES-1].tag;
    assign io.out_nan   = stg_data[STAGES-1].nan;
endmodule

// File: tb/tb_svfloat_sign_pipe.sv
module tb_svfloat_sign_pipe;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // u1: plain, u2: canonical NaN (both LANES=1, STAGES=2); u3: LANES=4, STAGES=3
    svfloat_sign_pipe_if #(.LANES(1), .FW(32), .TAG_W(4)) i1 ();
    svfloat_sign_pipe_if #(.LANES(1), .FW(32), .TAG_W(4)) i2 ();
    svfloat_sign_pipe_if #(.LANES(4), .FW(32), .TAG_W(8)) i3 ();

    svfloat_sign_pipe #(.LANES(1), .STAGES(2), .TAG_W(4), .CANON_NAN(1'b0)) u1 (.clk(clk), .rst(rst), .io(i1));
    svfloat_sign_pipe #(.LANES(1), .STAGES(2), .TAG_W(4), .CANON_NAN(1'b1)) u2 (.clk(clk), .rst(rst), .io(i2));
    svfloat_sign_pipe #(.LANES(4), .STAGES(3), .TAG_W(8), .CANON_NAN(1'b0)) u3 (.clk(clk), .rst(rst), .io(i3));

    typedef struct {
        logic [127:0] res;
        logic [7:0]   tag;
        logic [3:0]   nan;
    } exp_t;

    exp_t       q[$];
    exp_t       cur;
    int         to_send, sent, rcvd;
    bit         popped;
    logic [7:0] tag_ctr = 8'd0;
    logic [3:0] tag1    = 4'd0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic bit is_nan(input logic [31:0] a);
        return (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
    endfunction

    // reference for one float32 lane, no canonicalisation
    function automatic logic [31:0] ref_lane(input logic [2:0] op, input logic presv,
                                             input logic [31:0] a, input logic [31:0] b);
        logic s;
        if (is_nan(a) && presv) return a;
        case (op)
            3'd1: s = !a[31];
            3'd2: s = 1'b0;
            3'd3: s = b[31];
            3'd4: s = !b[31];
            3'd5: s = a[31] ^ b[31];
            3'd6: s = 1'b1;
            default: s = a[31];
        endcase
        return {s, a[30:0]};
    endfunction

    task automatic new_beat();
        logic [31:0] a, b;
        logic [2:0]  op;
        logic        presv;
        if (to_send == 0) begin
            i3.in_valid = 1'b0;
            return;
        end
        op    = 3'($urandom_range(7));
        presv = 1'($urandom_range(1));
        i3.in_op        = op;
        i3.in_presv_nan = presv;
        for (int l = 0; l < 4; l++) begin
            a = $urandom;
            if ($urandom_range(3) == 0) a[30:23] = 8'hFF;
            b = $urandom;
            i3.in_a[l] = a;
            i3.in_b[l] = b;
            cur.res[l*32 +: 32] = ref_lane(op, presv, a, b);
            cur.nan[l]          = is_nan(a);
        end
        cur.tag     = tag_ctr;
        i3.in_tag   = tag_ctr;
        tag_ctr     = tag_ctr + 8'd1;
        to_send--;
        i3.in_valid = 1'b1;
    endtask

    // one u3 cycle: observe both handshakes mid-cycle, then step past the edge
    task automatic cyc3();
        bit   acc;
        exp_t e;
        acc    = 1'b0;
        popped = 1'b0;
        @(negedge clk);
        if (i3.in_valid && i3.in_ready) begin
            q.push_back(cur);
            sent++;
            acc = 1'b1;
        end
        if (i3.out_valid && i3.out_ready) begin
            popped = 1'b1;
            rcvd++;
            chk("sb_nonempty", 128'(q.size() != 0), 128'd1);
            if (q.size() != 0) begin
                e = q.pop_front();
                chk("u3_res", i3.out_res, e.res);
                chk("u3_tag", 128'(i3.out_tag), 128'(e.tag));
                chk("u3_nan", 128'(i3.out_nan), 128'(e.nan));
            end
        end
        @(posedge clk);
        #1;
        if (acc) new_beat();
    endtask

    // single beat through u1 and u2; result must show exactly 2 cycles later
    task automatic run1(input string tag, input logic [2:0] op, input logic presv,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] e1, input logic [31:0] e2, input logic en);
        i1.in_op = op; i1.in_presv_nan = presv; i1.in_a = a; i1.in_b = b; i1.in_tag = tag1;
        i2.in_op = op; i2.in_presv_nan = presv; i2.in_a = a; i2.in_b = b; i2.in_tag = tag1;
        i1.in_valid = 1'b1; i2.in_valid = 1'b1;
        i1.out_ready = 1'b1; i2.out_ready = 1'b1;
        #1;
        chk({tag, "_inrdy"}, 128'(i1.in_ready), 128'd1);
        @(posedge clk); #1;
        i1.in_valid = 1'b0; i2.in_valid = 1'b0;
        chk({tag, "_early"}, 128'(i1.out_valid), 128'd0);
        @(posedge clk); #1;
        chk({tag, "_vld"},   128'(i1.out_valid), 128'd1);
        chk({tag, "_res"},   128'(i1.out_res),   128'(e1));
        chk({tag, "_nan"},   128'(i1.out_nan),   128'(en));
        chk({tag, "_tag"},   128'(i1.out_tag),   128'(tag1));
        chk({tag, "_cvld"},  128'(i2.out_valid), 128'd1);
        chk({tag, "_cres"},  128'(i2.out_res),   128'(e2));
        chk({tag, "_cnan"},  128'(i2.out_nan),   128'(en));
        tag1 = tag1 + 4'd1;
    endtask

    initial begin
        int first, last, stale;
        i1.in_valid = 0; i1.in_op = 0; i1.in_presv_nan = 0; i1.in_a = '0; i1.in_b = '0; i1.in_tag = '0; i1.out_ready = 0;
        i2.in_valid = 0; i2.in_op = 0; i2.in_presv_nan = 0; i2.in_a = '0; i2.in_b = '0; i2.in_tag = '0; i2.out_ready = 0;
        i3.in_valid = 0; i3.in_op = 0; i3.in_presv_nan = 0; i3.in_a = '0; i3.in_b = '0; i3.in_tag = '0; i3.out_ready = 0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("rst_u1_vld", 128'(i1.out_valid), 128'd0);
        chk("rst_u1_rdy", 128'(i1.in_ready),  128'd1);
        chk("rst_u1_res", 128'(i1.out_res),   128'd0);
        chk("rst_u3_vld", 128'(i3.out_valid), 128'd0);
        chk("rst_u3_res", i3.out_res,         128'd0);

        // directed single-lane vectors: op, presv, a, b, plain result, canon result, nan
        run1("neg",     3'd1, 1'b0, 32'h3F800000, 32'h0,        32'hBF800000, 32'hBF800000, 1'b0);
        run1("sgnjx",   3'd5, 1'b0, 32'hBF800000, 32'h80000000, 32'h3F800000, 32'h3F800000, 1'b0);
        run1("sgnj",    3'd3, 1'b0, 32'h40490FDB, 32'h80000000, 32'hC0490FDB, 32'hC0490FDB, 1'b0);
        run1("abs_inf", 3'd2, 1'b0, 32'hFF800000, 32'h0,        32'h7F800000, 32'h7F800000, 1'b0);
        run1("op7",     3'd7, 1'b0, 32'h12345678, 32'h0,        32'h12345678, 32'h12345678, 1'b0);
        run1("nabs",    3'd6, 1'b0, 32'h3F800000, 32'h0,        32'hBF800000, 32'hBF800000, 1'b0);
        run1("sgnjn",   3'd4, 1'b0, 32'h3F800000, 32'h00000000, 32'hBF800000, 32'hBF800000, 1'b0);
        run1("pass_z",  3'd0, 1'b0, 32'h80000000, 32'h0,        32'h80000000, 32'h80000000, 1'b0);
        run1("nan_p1",  3'd1, 1'b1, 32'hFFC00001, 32'h0,        32'hFFC00001, 32'h7FC00000, 1'b1);
        run1("nan_p0",  3'd1, 1'b0, 32'hFFC00001, 32'h0,        32'h7FC00001, 32'h7FC00000, 1'b1);
        run1("nan_abs", 3'd2, 1'b0, 32'h7F800001, 32'h0,        32'h7F800001, 32'h7FC00000, 1'b1);
        run1("nan_sj",  3'd3, 1'b1, 32'hFF800001, 32'h0,        32'hFF800001, 32'h7FC00000, 1'b1);

        // random backpressure, 20 beats
        sent = 0; rcvd = 0; to_send = 20;
        new_beat();
        for (int c = 0; c < 600 && rcvd < 20; c++) begin
            i3.out_ready = 1'($urandom_range(1));
            cyc3();
        end
        chk("rnd_sent", 128'(sent),     128'd20);
        chk("rnd_rcvd", 128'(rcvd),     128'd20);
        chk("rnd_left", 128'(q.size()), 128'd0);

        // full throughput: first result 3 cycles in, then one per cycle
        sent = 0; rcvd = 0; to_send = 20; first = -1; last = -1;
        i3.out_ready = 1'b1;
        new_beat();
        for (int c = 0; c < 40; c++) begin
            cyc3();
            if (popped) begin
                if (first < 0) first = c;
                last = c;
            end
        end
        chk("thr_first", 128'(first), 128'd3);
        chk("thr_last",  128'(last),  128'd22);
        chk("thr_rcvd",  128'(rcvd),  128'd20);

        // stall: fill, then a single-cycle release moves one beat each way
        sent = 0; rcvd = 0; to_send = 5;
        i3.out_ready = 1'b0;
        new_beat();
        repeat (5) cyc3();
        chk("stl_fill",  128'(sent),        128'd3);
        chk("stl_rdy0",  128'(i3.in_ready), 128'd0);
        i3.out_ready = 1'b1;
        #1;
        chk("stl_rdy1",  128'(i3.in_ready),  128'd1);
        chk("stl_ovld",  128'(i3.out_valid), 128'd1);
        cyc3();
        i3.out_ready = 1'b0;
        #1;
        chk("stl_sent1", 128'(sent),         128'd4);
        chk("stl_rcvd1", 128'(rcvd),         128'd1);
        chk("stl_rdy2",  128'(i3.in_ready),  128'd0);
        chk("stl_full",  128'(i3.out_valid), 128'd1);
        i3.out_ready = 1'b1;
        for (int c = 0; c < 50 && rcvd < 5; c++) cyc3();
        chk("stl_rcvd",  128'(rcvd),     128'd5);
        chk("stl_left",  128'(q.size()), 128'd0);

        // reset with 3 beats in flight
        sent = 0; rcvd = 0; to_send = 3;
        i3.out_ready = 1'b0;
        new_beat();
        repeat (4) cyc3();
        chk("mid_inflt", 128'(sent), 128'd3);
        rst = 1'b1;
        i3.in_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        q.delete();
        #1;
        chk("mid_vld", 128'(i3.out_valid), 128'd0);
        chk("mid_rdy", 128'(i3.in_ready),  128'd1);
        chk("mid_res", i3.out_res,         128'd0);
        chk("mid_tag", 128'(i3.out_tag),   128'd0);
        chk("mid_nan", 128'(i3.out_nan),   128'd0);
        i3.out_ready = 1'b1;
        stale = 0;
        repeat (10) begin
            @(negedge clk);
            if (i3.out_valid) stale++;
        end
        chk("mid_stale", 128'(stale), 128'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
